// File: rtl/sfq_chk_pkg.sv
// Shared definitions for the SFQ sync-output checker.
//   MODE_*  : encodings for the EXP_MODE parameter (expected pulse pattern)
//   HIST_W  : depth of the optional pulse-history window
//   chk_state_e : checker FSM states
package sfq_chk_pkg;
  localparam int MODE_ALWAYS0 = 0;
  localparam int MODE_ALWAYS1 = 1;
  localparam int MODE_ALT     = 2;
  localparam int HIST_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } chk_state_e;
endpackage

// File: rtl/sfq_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-high reset.
// Ports:
//   clk, reset : clock, async reset (counter -> 0)
//   inc_i      : count one this cycle (ignored once at all-ones)
//   clr_i      : synchronous clear, wins over inc_i
//   cnt_o      : current count
module sfq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/sfq_sync_out_checker.sv
// Checks a per-clock pulse strobe from a constant/toggling SFQ cell against
// an expected pattern, counting checked cycles and mismatches, capturing the
// index of the first mismatch and halting after MAX_FAIL mismatches.
// Optional feature macro: SFQ_CHK_HISTORY_EN (adds hist output).
// Ports:
//   clk, reset   : checker clock, async active-high reset
//   en           : level, run checking (0 -> IDLE)
//   clear        : strobe, zero counters/error state; HALT -> IDLE
//   pulse_in     : cell output seen this clock window
//   err          : registered per-cycle mismatch
//   err_sticky   : set on first mismatch, held until clear/reset
//   halted       : FSM in HALT
//   cycle_cnt    : checked cycles (saturating)
//   fail_cnt     : mismatches (saturating)
//   first_fail   : cycle_cnt value of the first mismatch
//   hist         : (SFQ_CHK_HISTORY_EN) last 8 checked samples frozen at
//                  first mismatch, bit0 = failing sample
module sfq_sync_out_checker
  import sfq_chk_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int EXP_MODE = 0,
  parameter int SETTLE   = 2,
  parameter int MAX_FAIL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             pulse_in,
  output logic             err,
  output logic             err_sticky,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] fail_cnt,
`ifdef SFQ_CHK_HISTORY_EN
  output logic [HIST_W-1:0] hist,
`endif
  output logic [CNT_W-1:0] first_fail
);
  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [CNT_W-1:0] FAIL_LAST   = CNT_W'(MAX_FAIL - 1);

  chk_state_e       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             tgl_q, tgl_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] ff_q, ff_d;
  logic             chk, exp_bit, mismatch, first_hit;

  // A check only happens in CHECK with en still high; en low exits instead.
  assign chk       = (state_q == ST_CHECK) && en;
  assign mismatch  = chk && (pulse_in != exp_bit);
  assign first_hit = mismatch && !sticky_q;

  always_comb begin
    exp_bit = 1'b0;
    if (EXP_MODE == MODE_ALWAYS1)  exp_bit = 1'b1;
    else if (EXP_MODE == MODE_ALT) exp_bit = tgl_q;
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tgl_d    = tgl_q;
    unique case (state_q)
      ST_IDLE: if (en) begin
        tgl_d    = 1'b0;
        settle_d = '0;
        state_d  = (SETTLE == 0) ? ST_CHECK : ST_ARM;
      end
      ST_ARM: begin
        if (!en)                          state_d = ST_IDLE;
        else if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                              settle_d = settle_q + 4'd1;
      end
      ST_CHECK: begin
        if (!en) state_d = ST_IDLE;
        else begin
          tgl_d = ~tgl_q;
          if (mismatch && (fail_cnt == FAIL_LAST)) state_d = ST_HALT;
        end
      end
      default: ;  // HALT: frozen until clear/reset
    endcase
    // clear suppresses a same-cycle halt and releases an existing one
    if (clear) begin
      if (state_q == ST_HALT)      state_d = ST_IDLE;
      else if (state_d == ST_HALT) state_d = state_q;
    end
  end

  always_comb begin
    err_d    = mismatch;
    sticky_d = sticky_q | mismatch;
    ff_d     = first_hit ? cycle_cnt : ff_q;
    if (clear) begin
      err_d    = 1'b0;
      sticky_d = 1'b0;
      ff_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      tgl_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tgl_q    <= tgl_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      ff_q     <= ff_d;
    end
  end

  sfq_sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .reset(reset), .inc_i(chk), .clr_i(clear), .cnt_o(cycle_cnt)
  );
  sfq_sat_counter #(.W(CNT_W)) u_fail (
    .clk(clk), .reset(reset), .inc_i(mismatch), .clr_i(clear), .cnt_o(fail_cnt)
  );

`ifdef SFQ_CHK_HISTORY_EN
  logic [HIST_W-1:0] sr_q, sr_d, hist_q, hist_d;

  always_comb begin
    sr_d   = chk ? {sr_q[HIST_W-2:0], pulse_in} : sr_q;
    hist_d = first_hit ? {sr_q[HIST_W-2:0], pulse_in} : hist_q;
    if (clear) begin
      sr_d   = '0;
      hist_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      hist_q <= '0;
    end else begin
      sr_q   <= sr_d;
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`endif

  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign halted     = (state_q == ST_HALT);
  assign first_fail = ff_q;
endmodule
